instr_encoder: RTL and testbench

- Inverse of the decode path: turns an ALU operation request (4-bit alu_op code, is_imm, register indices, immediate) into a 32-bit RV32I instruction word.
- Buffers encoded words in a small FIFO.
- Streams each word with its instruction-memory byte address over a valid/ready interface.
- Used by the test/boot loader to fill instruction memory.

---
 rtl/instr_encoder.sv | 146 ++++++++++++++
 tb/tb_instr_encoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Encodes ALU operation requests into RV32I instruction words,
//            buffers them in a small FIFO and streams each word together
//            with its instruction-memory byte address.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_alu_op,
  input  logic              in_is_imm,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  input  logic              addr_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_addr,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count
);

  localparam int              c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(DEPTH);

  logic [31:0]        r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic [31:0]        r_addr;
  logic               r_err_pulse;
  logic [ERR_W-1:0]   r_err_count;

  logic [31:0]        w_word;
  logic               w_op_ok;
  logic [6:0]         w_funct7;
  logic [2:0]         w_funct3;
  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_push;
  logic               w_bad;
  logic               w_pop;

  assign w_full   = (r_count == c_FULL);
  assign w_empty  = (r_count == '0);
  assign w_accept = in_valid & ~w_full;
  assign w_push   = w_accept & w_op_ok;
  assign w_bad    = w_accept & ~w_op_ok;
  assign w_pop    = ~w_empty & out_ready;

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  // Head word is forced to zero when empty so reset shows a clean bus.
  assign out_instr = w_empty ? 32'h0 : r_mem[r_rd_ptr];
  assign out_addr  = r_addr;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

  // Encode the request and flag opcodes that have no legal encoding.
  always_comb begin
    w_op_ok  = 1'b0;
    w_funct7 = 7'b0000000;
    w_funct3 = 3'b000;
    w_word   = 32'h0;
    if (in_is_imm) begin
      // Only ADDI exists on the immediate path.
      w_op_ok = (in_alu_op == 4'b0000);
      w_word  = {in_imm, in_rs1, 3'b000, in_rd, 7'b0010011};
    end else begin
      case (in_alu_op)
        4'b0000: begin w_op_ok = 1'b1; end
        4'b0001: begin w_op_ok = 1'b1; w_funct7 = 7'b0100000; end
        4'b0010: begin w_op_ok = 1'b1; w_funct3 = 3'b111; end
        4'b0011: begin w_op_ok = 1'b1; w_funct3 = 3'b110; end
        4'b0100: begin w_op_ok = 1'b1; w_funct3 = 3'b100; end
        default: begin w_op_ok = 1'b0; end
      endcase
      w_word = {w_funct7, in_rs2, in_rs1, w_funct3, in_rd, 7'b0110011};
    end
  end

  // FIFO storage; contents need no reset because the head is gated by count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is 2^n.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Byte address of the head word; clear wins over a simultaneous pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= BASE_ADDR;
    end else if (addr_clear) begin
      r_addr <= BASE_ADDR;
    end else if (w_pop) begin
      r_addr <= r_addr + 32'd4;
    end
  end

  // Error pulse and saturating counter for consumed-but-dropped requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_bad;
      if (w_bad && (r_err_count != {ERR_W{1'b1}})) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Self-checking bench for instr_encoder against a queue-based
//            reference model; directed scenarios followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  localparam int          DEPTH     = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
  localparam int          ERR_W     = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_alu_op;
  logic             in_is_imm;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [11:0]      in_imm;
  logic             addr_clear;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_addr;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  instr_encoder #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_is_imm(in_is_imm),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .addr_clear(addr_clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] q_word[$];
  logic [31:0] m_addr;
  int          m_err;
  logic        m_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Encoding straight from the instruction-format field tables.
  function automatic bit ref_encode(input int op, input int imm_f, input int rd,
                                    input int rs1, input int rs2, input int imm,
                                    output logic [31:0] w);
    int     f3 [5] = '{0, 0, 7, 6, 4};
    longint v;
    w = 32'h0;
    if (imm_f != 0) begin
      if (op != 0) return 1'b0;
      v = longint'(imm) * (2**20) + rs1 * (2**15) + rd * (2**7) + 19;
    end else begin
      if (op > 4) return 1'b0;
      v = longint'((op == 1) ? 32 : 0) * (2**25) + rs2 * (2**20) + rs1 * (2**15)
          + f3[op] * (2**12) + rd * (2**7) + 51;
    end
    w = v[31:0];
    return 1'b1;
  endfunction

  task automatic check_outputs();
    check("in_ready", {31'h0, in_ready}, (q_word.size() < DEPTH) ? 32'h1 : 32'h0);
    check("out_valid", {31'h0, out_valid}, (q_word.size() > 0) ? 32'h1 : 32'h0);
    if (q_word.size() > 0) check("out_instr", out_instr, q_word[0]);
    check("out_addr", out_addr, m_addr);
    check("err_pulse", {31'h0, err_pulse}, {31'h0, m_pulse});
    check("err_count", {24'h0, err_count}, m_err);
  endtask

  // One clock: predict from pre-edge state and inputs, then compare after the edge.
  task automatic cycle();
    logic [31:0] w;
    bit ok, acc, pop;
    ok  = ref_encode(in_alu_op, in_is_imm, in_rd, in_rs1, in_rs2, in_imm, w);
    acc = in_valid && (q_word.size() < DEPTH);
    pop = out_ready && (q_word.size() > 0);
    @(posedge clk);
    if (pop) void'(q_word.pop_front());
    if (addr_clear) m_addr = BASE_ADDR;
    else if (pop) m_addr = m_addr + 32'd4;
    if (acc && ok) q_word.push_back(w);
    m_pulse = acc && !ok;
    if (acc && !ok && m_err < 255) m_err++;
    #1;
    check_outputs();
  endtask

  task automatic req(input int op, input int imm_f, input int rd, input int rs1,
                     input int rs2, input int imm);
    in_valid  = 1'b1;
    in_alu_op = op[3:0];
    in_is_imm = imm_f[0];
    in_rd     = rd[4:0];
    in_rs1    = rs1[4:0];
    in_rs2    = rs2[4:0];
    in_imm    = imm[11:0];
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic model_reset();
    q_word.delete();
    m_addr  = BASE_ADDR;
    m_err   = 0;
    m_pulse = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_alu_op = '0; in_is_imm = 1'b0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    addr_clear = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_outputs();
    check("reset_instr", out_instr, 32'h0);

    // Single ADD, visible the cycle after the push
    req(0, 0, 1, 2, 3, 0);
    cycle();
    check("add_word", out_instr, 32'h003100B3);
    check("add_addr", out_addr, 32'h0);
    idle(); out_ready = 1'b1;
    cycle();
    out_ready = 1'b0; addr_clear = 1'b1;
    cycle();
    addr_clear = 1'b0;

    // SUB then ADDI streaming through
    out_ready = 1'b1;
    req(1, 0, 5, 6, 7, 0);
    cycle();
    check("sub_word", out_instr, 32'h407302B3);
    req(0, 1, 1, 0, 0, 12'h7FF);
    cycle();
    check("addi_word", out_instr, 32'h7FF00093);
    check("addi_addr", out_addr, 32'h4);
    idle();
    cycle();
    addr_clear = 1'b1; cycle(); addr_clear = 1'b0;

    // Fill past capacity with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req(i, 0, i + 1, i + 2, i + 3, 0);
      cycle();
    end
    check("full_ready", {31'h0, in_ready}, 32'h0);
    cycle();
    out_ready = 1'b1;
    cycle();
    idle();
    repeat (6) cycle();

    // Invalid requests and counter saturation
    req(15, 0, 1, 1, 1, 0); cycle();
    req(1, 1, 1, 1, 1, 5);  cycle();
    idle(); cycle();
    check("err_two", {24'h0, err_count}, 32'd2);
    check("err_empty", {31'h0, out_valid}, 32'h0);
    req(9, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) cycle();
    idle(); cycle();
    check("err_sat", {24'h0, err_count}, 32'hFF);

    // Clear on pop, then push+pop at occupancy 2
    out_ready = 1'b0;
    req(2, 0, 3, 4, 5, 0); cycle();
    req(3, 0, 6, 7, 8, 0); cycle();
    req(4, 0, 9, 10, 11, 0); cycle();
    idle(); out_ready = 1'b1; addr_clear = 1'b1;
    cycle();
    addr_clear = 1'b0;
    check("clr_addr", out_addr, BASE_ADDR);
    req(0, 1, 12, 13, 0, 12'h123);
    cycle();
    idle();
    repeat (4) cycle();

    // Asynchronous reset with queued words
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin req(i, 0, i, i, i, 0); cycle(); end
    idle();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'h0, out_valid}, 32'h0);
    check("arst_addr", out_addr, BASE_ADDR);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    check_outputs();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_alu_op = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
      in_is_imm = ($urandom_range(0, 3) == 0);
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_imm    = 12'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      addr_clear = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
